// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between requesting agents and the round-robin arbiter.
//   en       : permits new grants (agent side drives)
//   req      : level request vector, one bit per requester
//   done     : release strobe from the granted requester
//   gnt      : one-hot grant (or 0), datapath mux select
//   gnt_idx  : index of current/last winner
//   busy     : high while any grant is active
//   timeout  : one-cycle pulse when a grant is forcibly revoked
//   hold_cnt : cycles the current grant has been high
interface rr_bus_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               busy;
  logic               timeout;
  logic [HW-1:0]      hold_cnt;

  modport master (output en, req, done,
                  input  gnt, gnt_idx, busy, timeout, hold_cnt);
  modport slave  (input  en, req, done,
                  output gnt, gnt_idx, busy, timeout, hold_cnt);
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one bus among NUM_REQ requesters.
// Rotating-priority winner selection feeds a grant-hold FSM (IDLE, GRANT,
// RECOVER) with release handshake, hold-timeout watchdog and a one-cycle
// turnaround bubble after every grant.
//   clock : system clock, posedge
//   reset : asynchronous, active-high; clears all state immediately
//   bus   : slave side of rr_bus_arbiter_if (en/req/done in, grant status out)
module rr_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clock,
  input  logic            reset,
  rr_bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [IW-1:0]      idx_q, idx_n;
  logic [IW-1:0]      ptr_q, ptr_n;
  logic [HW-1:0]      hold_q, hold_n;
  logic               to_q, to_n;

  logic [IW-1:0]      winner, cand;
  logic               found;

  // Rotating scan from ptr; IW-bit addition wraps because NUM_REQ is a power of 2.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + IW'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    to_n    = 1'b0;   // timeout is a single-cycle pulse
    unique case (state)
      IDLE, RECOVER: begin
        if (bus.en && found) begin
          state_n        = GRANT;
          gnt_n          = '0;
          gnt_n[winner]  = 1'b1;
          idx_n          = winner;
          hold_n         = HW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        // Normal release takes precedence over the watchdog in the same cycle.
        if (bus.done[idx_q] || !bus.req[idx_q]) begin
          state_n = RECOVER;
          gnt_n   = '0;
          hold_n  = '0;
          ptr_n   = idx_q + IW'(1);
        end else if (hold_q == HW'(MAX_HOLD)) begin
          state_n = RECOVER;
          gnt_n   = '0;
          hold_n  = '0;
          ptr_n   = idx_q + IW'(1);
          to_n    = 1'b1;
        end else begin
          hold_n  = hold_q + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= '0;
      idx_q  <= '0;
      ptr_q  <= '0;
      hold_q <= '0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      idx_q  <= idx_n;
      ptr_q  <= ptr_n;
      hold_q <= hold_n;
      to_q   <= to_n;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_idx  = idx_q;
  assign bus.busy     = |gnt_q;
  assign bus.timeout  = to_q;
  assign bus.hold_cnt = hold_q;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural owner/ptr model of the arbitration rules.
module tb_rr_bus_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_bus_arbiter_if #(.NUM_REQ(N), .MAX_HOLD(MH)) bus ();
  rr_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  // Model: owner = requester holding the bus, -1 when none.
  int m_owner, m_hold, m_ptr, m_last;
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1; m_hold = 0; m_ptr = 0; m_last = 0; m_to = 0;
  endtask

  task automatic m_edge();
    m_to = 0;
    if (m_owner >= 0) begin
      if (bus.done[m_owner] || !bus.req[m_owner] || m_hold == MH) begin
        m_to    = !(bus.done[m_owner] || !bus.req[m_owner]);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_hold  = 0;
      end else m_hold++;
    end else if (bus.en && bus.req != 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && bus.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_last = m_owner;
      m_hold = 1;
    end
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk({tag, ".gnt"},     32'(bus.gnt),      eg);
    chk({tag, ".idx"},     32'(bus.gnt_idx),  32'(m_last));
    chk({tag, ".busy"},    32'(bus.busy),     32'(m_owner >= 0));
    chk({tag, ".timeout"}, 32'(bus.timeout),  32'(m_to));
    chk({tag, ".hold"},    32'(bus.hold_cnt), 32'(m_hold));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.req = '0; bus.done = '0;
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk_model("reset");
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.req = '0; bus.done = '0;
    m_reset();
    #1 chk_model("por");
    @(negedge clk) rst = 1'b0;

    // 1: full request set rotates 0,1,2,3 with bubbles, then back to 0
    bus.en = 1'b1; bus.req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.done = '0;
      step("t1g");
      chk("t1.gnt_on", 32'(bus.gnt), 32'd1 << i);
      bus.done = 4'(1 << i);
      step("t1r");
      chk("t1.gnt_off", 32'(bus.gnt), 32'd0);
      chk("t1.no_to", 32'(bus.timeout), 32'd0);
    end
    bus.done = '0;
    step("t1w");
    chk("t1.wrap", 32'(bus.gnt), 32'b0001);

    // 2: sole requester, no done -> exactly MAX_HOLD cycles, timeout, re-grant
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0100;
    for (int c = 1; c <= MH; c++) begin
      step("t2h");
      chk("t2.held", 32'(bus.gnt), 32'b0100);
      chk("t2.cnt", 32'(bus.hold_cnt), 32'(c));
    end
    step("t2t");
    chk("t2.to_gnt", 32'(bus.gnt), 32'd0);
    chk("t2.to", 32'(bus.timeout), 32'd1);
    step("t2g");
    chk("t2.regrant", 32'(bus.gnt), 32'b0100);
    chk("t2.to_clr", 32'(bus.timeout), 32'd0);

    // 3: en gating of new grants only
    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step("t3e");
      chk("t3.no_gnt", 32'(bus.gnt), 32'd0);
      chk("t3.no_busy", 32'(bus.busy), 32'd0);
    end
    bus.en = 1'b1;
    step("t3g");
    chk("t3.gnt", 32'(bus.gnt), 32'b0001);
    bus.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step("t3k");
      chk("t3.keep", 32'(bus.gnt), 32'b0001);
    end
    bus.done = 4'b0001;
    step("t3d");
    chk("t3.rel", 32'(bus.gnt), 32'd0);
    bus.done = '0;

    // 4: dropping req releases; pointer moves past the released requester
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0010;
    step("t4g");
    chk("t4.gnt", 32'(bus.gnt), 32'b0010);
    bus.req = 4'b0101;
    step("t4r");
    chk("t4.drop", 32'(bus.gnt), 32'd0);
    chk("t4.no_to", 32'(bus.timeout), 32'd0);
    step("t4n");
    chk("t4.next", 32'(bus.gnt), 32'b0100);

    // 5: async reset mid-grant, then pointer restarts at 0
    do_reset();
    bus.en = 1'b1; bus.req = 4'b1000;
    step("t5g");
    chk("t5.gnt", 32'(bus.gnt), 32'b1000);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("t5.async_gnt", 32'(bus.gnt), 32'd0);
    chk("t5.async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk) rst = 1'b0;
    bus.req = 4'b1001;
    step("t5p");
    chk("t5.ptr0", 32'(bus.gnt), 32'b0001);

    // 6: foreign done ignored; done on the MAX_HOLD cycle is a normal release
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0100;
    step("t6g");
    bus.done = 4'b0001;
    step("t6f");
    chk("t6.ignore", 32'(bus.gnt), 32'b0100);
    bus.done = '0;
    for (int c = 0; c < MH - 2; c++) step("t6h");
    chk("t6.at_max", 32'(bus.hold_cnt), 32'(MH));
    bus.done = 4'b0100;
    step("t6r");
    chk("t6.rel", 32'(bus.gnt), 32'd0);
    chk("t6.no_to", 32'(bus.timeout), 32'd0);
    bus.done = '0;

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.en   = ($urandom_range(0, 4) != 0);
      bus.req  = 4'($urandom);
      bus.done = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step("rnd");
      if (bus.gnt != 0) chk("rnd.onehot", 32'($onehot(bus.gnt)), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
